mem_1r1w_bist: RTL and testbench
================================

# mem_1r1w_bist

Built-in self-test engine for the lowered two-port (one read, one write) SRAM wrappers. It acts as the initiator on the wrapper's R0/W0 ports. On request it runs a fixed March sequence over every word and checks read data against expected patterns. It reports pass/fail, a saturating error count and a syndrome for the first mismatch. It sits between the SoC test controller and one 1r1w memory instance, which it drives through a mux during test mode.

## Interface
Parameters:
- DEPTH, 48: number of words in the target memory.
- WIDTH, 64: word width in bits.
- ADDR_W, 6: address width, equal to ceil(log2(DEPTH)).

Ports:
- clock  in  1  the single clock for the block. The memory's R0_clk and W0_clk are tied to this clock externally.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to run the test.
- busy  out  1  high while the March sequence is in progress.
- done  out  1  level signal. High after a run completes and held until the next accepted start or reset.
- fail  out  1  sticky. High once any mismatch has occurred in the current run.
- err_cnt  out  8  number of mismatches in the current run, saturating at 255.
- fail_addr  out  ADDR_W  address of the first mismatch.
- fail_syn  out  WIDTH  syndrome of the first mismatch, R0_data XOR expected.
- W0_addr  out  ADDR_W  memory write address.
- W0_en  out  1  memory write enable.
- W0_data  out  WIDTH  memory write data.
- R0_addr  out  ADDR_W  memory read address.
- R0_en  out  1  memory read enable.
- R0_data  in  WIDTH  memory read data. Valid exactly one cycle after the cycle in which R0_en is high.

## Operation
- Pattern P: bit i = 1 when i is even, so P = 64'h5555_5555_5555_5555 for WIDTH=64. ~P is its bitwise complement.
- The sequence has four March elements, with a as the current address:
  - E0, ascending: write P.
  - E1, ascending: read expecting P, then write ~P.
  - E2, descending: read expecting ~P, then write P.
  - E3, ascending: read expecting P.
- FSM states: IDLE, E0_W, E1_R, E1_W, E2_R, E2_W, E3_R, E3_C, DONE.
- Per-state actions:
  - E0_W: one cycle per address, W0_en=1.
  - *_R states: R0_en=1 at address a.
  - Following E1_W, E2_W or E3_C: compare R0_data with the expected value. In E1_W and E2_W, also write the new value to the same a.
- Reads and writes never target the same address in the same cycle.
- Address counter:
  - Ascending elements: 0 up to DEPTH-1.
  - Descending element: DEPTH-1 down to 0.
  - After the last address of an element, advance to the first state of the next element and reload the counter.
  - DEPTH need not be a power of two. Addresses of DEPTH and above are never issued.
- Transitions:
  - IDLE or DONE, with start=1: go to E0_W with a=0. Clear fail, err_cnt, fail_addr and fail_syn. Clear done.
  - E3_C at a=DEPTH-1: go to DONE.
  - start is ignored while busy=1.
- Compare rule:
  - A mismatch increments err_cnt, saturating at 255, and sets fail.
  - fail_addr and fail_syn are captured only when fail was 0 before this compare.
- Memory outputs:
  - All memory outputs are registered or Moore-decoded from state and a, with no combinational path from start.
  - W0_data is driven 0 and R0_addr/W0_addr hold a when the corresponding enable is low.
  - R0_en and W0_en are 0 in IDLE and DONE.

## Timing
- Reset, whether at power-up or mid-run, takes effect at the next clock edge. The state becomes IDLE and every output is 0: busy, done, fail, err_cnt, fail_addr, fail_syn, both enables, both addresses and W0_data.
- If start is sampled high at edge k, busy=1 and W0_en=1 with W0_addr=0 from edge k through edge k+1.
- Run length is 7*DEPTH cycles (336 for DEPTH=48):
  - E0: DEPTH cycles.
  - E1, E2, E3: 2*DEPTH cycles each.
- busy falls and done rises at edge k+7*DEPTH.
- Totals per run: 3*DEPTH write cycles and 3*DEPTH read cycles.
- Read latency is one cycle. The compare uses R0_data in the cycle immediately after R0_en.
- Reset asserted mid-run aborts without completing. The memory contents are then undefined, and no done pulse is produced.

## Test plan
- Reset: hold reset_n=0 for 3 cycles, release it and keep start=0 -> all outputs are 0 and remain 0 for 20 cycles.
- Clean run on a fault-free 1-cycle-latency memory model: pulse start -> busy is high for exactly 336 cycles, with 144 W0_en cycles and 144 R0_en cycles. Then done=1, fail=0, err_cnt=0. The final memory contents are P at all 48 addresses.
- Stuck-at-0 on bit 0 at address 17 -> fail=1, fail_addr=17, fail_syn=64'h1, err_cnt=2 (mismatches in E1 and E3; E2 passes). fail_addr is unchanged by the second error.
- All 64 bits stuck-at-1 on every address -> err_cnt=144 and fail_addr=0. fail_syn is 64'hAAAA_AAAA_AAAA_AAAA. Then repeat on a DEPTH=300 instance with all bits stuck -> err_cnt saturates at 255.
- Protocol: pulse start again at cycle 100 of a run -> it is ignored and the run still ends at cycle 336. A start after done -> fail, err_cnt and done all clear, and a second identical run follows.
- Reset mid-run: drop reset_n during E2 -> at the next edge busy=0, both enables are 0 and done=0. A subsequent start performs a full clean run.

Source files
------------

// File: rtl/mem_1r1w_bist.sv
// rtl/mem_1r1w_bist.sv - March BIST initiator for a 1r1w SRAM wrapper
// Runs E0..E3 over every word and records pass/fail, error count and first syndrome.
module mem_1r1w_bist #(
  parameter int DEPTH  = 48,
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [7:0]        err_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [WIDTH-1:0]  fail_syn,
  output logic [ADDR_W-1:0] W0_addr,
  output logic              W0_en,
  output logic [WIDTH-1:0]  W0_data,
  output logic [ADDR_W-1:0] R0_addr,
  output logic              R0_en,
  input  logic [WIDTH-1:0]  R0_data
);

  function automatic logic [WIDTH-1:0] pat_gen();
    logic [WIDTH-1:0] p;
    for (int i = 0; i < WIDTH; i++) p[i] = ~i[0];
    return p;
  endfunction

  localparam logic [WIDTH-1:0]  PAT  = pat_gen();
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [3:0] {
    IDLE, E0_W, E1_R, E1_W, E2_R, E2_W, E3_R, E3_C, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              cmp_en;
  logic              start_acc;
  logic [WIDTH-1:0]  exp_data;
  logic [WIDTH-1:0]  syn;

  assign syn = R0_data ^ exp_data;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cmp_en    = 1'b0;
    start_acc = 1'b0;
    exp_data  = '0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = E0_W;
          addr_d    = '0;
        end
      end
      E0_W: begin
        if (addr_q == LAST) begin
          state_d = E1_R;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      E1_R: state_d = E1_W;
      E1_W: begin
        cmp_en   = 1'b1;
        exp_data = PAT;
        // Descending element starts at the address we just finished on.
        if (addr_q == LAST) begin
          state_d = E2_R;
        end else begin
          state_d = E1_R;
          addr_d  = addr_q + ADDR_W'(1);
        end
      end
      E2_R: state_d = E2_W;
      E2_W: begin
        cmp_en   = 1'b1;
        exp_data = ~PAT;
        if (addr_q == '0) begin
          state_d = E3_R;
        end else begin
          state_d = E2_R;
          addr_d  = addr_q - ADDR_W'(1);
        end
      end
      E3_R: state_d = E3_C;
      E3_C: begin
        cmp_en   = 1'b1;
        exp_data = PAT;
        if (addr_q == LAST) begin
          state_d = DONE;
          addr_d  = '0;
        end else begin
          state_d = E3_R;
          addr_d  = addr_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        addr_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      fail      <= 1'b0;
      err_cnt   <= '0;
      fail_addr <= '0;
      fail_syn  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      if (start_acc) begin
        fail      <= 1'b0;
        err_cnt   <= '0;
        fail_addr <= '0;
        fail_syn  <= '0;
      end else if (cmp_en && (syn != '0)) begin
        fail <= 1'b1;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        if (!fail) begin
          fail_addr <= addr_q;
          fail_syn  <= syn;
        end
      end
    end
  end

  // Memory-side outputs are Moore-decoded from state and address only.
  always_comb begin
    W0_en   = 1'b0;
    R0_en   = 1'b0;
    W0_data = '0;
    case (state_q)
      E0_W, E2_W: begin W0_en = 1'b1; W0_data = PAT;  end
      E1_W:       begin W0_en = 1'b1; W0_data = ~PAT; end
      E1_R, E2_R, E3_R: R0_en = 1'b1;
      default: ;
    endcase
  end

  assign W0_addr = addr_q;
  assign R0_addr = addr_q;
  assign busy    = (state_q != IDLE) && (state_q != DONE);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_mem_1r1w_bist.sv
// tb/tb_mem_1r1w_bist.sv - directed self-checking bench for mem_1r1w_bist
// Drives a 1-cycle-latency memory model with selectable read faults.
module tb_mem_1r1w_bist;
  localparam logic [63:0] P  = 64'h5555_5555_5555_5555;
  localparam logic [63:0] NP = 64'hAAAA_AAAA_AAAA_AAAA;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, fail;
  logic [7:0]  err_cnt;
  logic [5:0]  fail_addr, W0_addr, R0_addr;
  logic [63:0] fail_syn, W0_data;
  logic        W0_en, R0_en;
  logic [63:0] R0_data = '0;

  logic        start2 = 1'b0;
  logic        busy2, done2, fail2, W0_en2, R0_en2;
  logic [7:0]  err_cnt2;
  logic [8:0]  fail_addr2, W0_addr2, R0_addr2;
  logic [63:0] fail_syn2, W0_data2;
  logic [63:0] R0_data2;

  logic [63:0] mem [48];
  int          fault_mode = 0;  // 0 none, 1 bit0 stuck-0 at addr 17, 2 all stuck-1
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  mem_1r1w_bist #(.DEPTH(48), .WIDTH(64), .ADDR_W(6)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .fail(fail), .err_cnt(err_cnt), .fail_addr(fail_addr), .fail_syn(fail_syn),
    .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data),
    .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(R0_data)
  );

  assign R0_data2 = '1;

  mem_1r1w_bist #(.DEPTH(300), .WIDTH(64), .ADDR_W(9)) dut2 (
    .clock(clock), .reset_n(reset_n), .start(start2), .busy(busy2), .done(done2),
    .fail(fail2), .err_cnt(err_cnt2), .fail_addr(fail_addr2), .fail_syn(fail_syn2),
    .W0_addr(W0_addr2), .W0_en(W0_en2), .W0_data(W0_data2),
    .R0_addr(R0_addr2), .R0_en(R0_en2), .R0_data(R0_data2)
  );

  always @(posedge clock) begin
    if (W0_en) mem[W0_addr] <= W0_data;
    if (R0_en) begin
      case (fault_mode)
        1:       R0_data <= (R0_addr == 6'd17) ? (mem[R0_addr] & ~64'h1) : mem[R0_addr];
        2:       R0_data <= '1;
        default: R0_data <= mem[R0_addr];
      endcase
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run(input int restart_at, output int bcyc, output int wcyc, output int rcyc);
    int cyc;
    bcyc = 0; wcyc = 0; rcyc = 0; cyc = 0;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("start_busy", {63'd0, busy}, 64'd1);
    check("start_w0en", {63'd0, W0_en}, 64'd1);
    check("start_w0addr", {58'd0, W0_addr}, 64'd0);
    check("start_clear", {54'd0, done, fail, err_cnt}, 64'd0);
    while (busy && cyc < 5000) begin
      bcyc++;
      if (W0_en) wcyc++;
      if (R0_en) rcyc++;
      cyc++;
      start = (cyc == restart_at);
      @(negedge clock);
    end
    start = 1'b0;
  endtask

  initial begin
    int b, w, r, bad, cyc;
    logic [63:0] acc;

    // Reset and quiet idle.
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    acc = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      acc = acc | {61'd0, busy, done, fail} | {56'd0, err_cnt} | {58'd0, fail_addr}
          | fail_syn | W0_data | {58'd0, W0_addr} | {58'd0, R0_addr} | {62'd0, W0_en, R0_en};
    end
    check("reset_idle_outputs", acc, 64'd0);

    // Clean run.
    run(-1, b, w, r);
    check("clean_busy_cycles", 64'(b), 64'd336);
    check("clean_w_cycles", 64'(w), 64'd144);
    check("clean_r_cycles", 64'(r), 64'd144);
    check("clean_done", {63'd0, done}, 64'd1);
    check("clean_fail", {63'd0, fail}, 64'd0);
    check("clean_err_cnt", {56'd0, err_cnt}, 64'd0);
    bad = 0;
    for (int i = 0; i < 48; i++) if (mem[i] !== P) bad++;
    check("clean_mem_final", 64'(bad), 64'd0);

    // Stuck-at-0 bit 0 at address 17.
    fault_mode = 1;
    run(-1, b, w, r);
    check("sa0_fail", {63'd0, fail}, 64'd1);
    check("sa0_fail_addr", {58'd0, fail_addr}, 64'd17);
    check("sa0_fail_syn", fail_syn, 64'h1);
    check("sa0_err_cnt", {56'd0, err_cnt}, 64'd2);
    check("sa0_done", {63'd0, done}, 64'd1);

    // Restart after done clears status; start at cycle 100 is ignored.
    fault_mode = 0;
    run(100, b, w, r);
    check("restart_busy_cycles", 64'(b), 64'd336);
    check("restart_fail", {63'd0, fail}, 64'd0);
    check("restart_err_cnt", {56'd0, err_cnt}, 64'd0);
    check("restart_done", {63'd0, done}, 64'd1);

    // All bits stuck-at-1.
    fault_mode = 2;
    run(-1, b, w, r);
    check("sa1_err_cnt", {56'd0, err_cnt}, 64'd144);
    check("sa1_fail_addr", {58'd0, fail_addr}, 64'd0);
    check("sa1_fail_syn", fail_syn, NP);
    fault_mode = 0;

    // DEPTH=300 instance, all stuck-at-1: count saturates.
    @(negedge clock);
    start2 = 1'b1;
    @(negedge clock);
    start2 = 1'b0;
    cyc = 0;
    while (busy2 && cyc < 5000) begin
      b = cyc;
      cyc++;
      @(negedge clock);
    end
    check("d300_busy_cycles", 64'(cyc), 64'd2100);
    check("d300_err_cnt", {56'd0, err_cnt2}, 64'd255);
    check("d300_fail", {63'd0, fail2}, 64'd1);
    check("d300_done", {63'd0, done2}, 64'd1);

    // Reset during E2 (E2 spans run cycles 144..239).
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (199) @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_enables", {62'd0, W0_en, R0_en}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    run(-1, b, w, r);
    check("post_rst_busy_cycles", 64'(b), 64'd336);
    check("post_rst_done", {63'd0, done}, 64'd1);
    check("post_rst_err_cnt", {56'd0, err_cnt}, 64'd0);
    bad = 0;
    for (int i = 0; i < 48; i++) if (mem[i] !== P) bad++;
    check("post_rst_mem_final", 64'(bad), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
